// File: rtl/hex_uart_tx.sv
// hex_uart_tx
// Prints a 32-bit word on a UART line as eight uppercase ASCII hex digits,
// most-significant nibble first, optionally followed by CR LF.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst          synchronous, active-high reset
//   din[31:0]    word to print; captured when a word is accepted
//   start        level-sampled request; accepted only while the FSM is in IDLE
//   txd          registered UART line, 8N1, idles high
//   busy         high from the cycle after acceptance through the done cycle
//   done         one-cycle pulse in the cycle after the last stop bit ends
//   o_dbg_state  current FSM state, exposed for debug and checkers
//
// Handshake: start acts as a level "valid"; the block is "ready" whenever it
// sits in IDLE. This includes the done cycle, so a start held high begins
// the next word straight away. A start seen in any other state is dropped
// and not queued.
module hex_uart_tx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200,
  parameter int NEWLINE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din,
  input  logic        start,
  output logic        txd,
  output logic        busy,
  output logic        done,
  output logic [2:0]  o_dbg_state
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int BW    = $clog2(DIV + 1);
  localparam int NCHAR = (NEWLINE != 0) ? 10 : 8;

  localparam logic [BW-1:0] DIV_M1   = BW'(DIV - 1);
  // STOP_BIT covers the first DIV-1 cycles of the stop bit. NEXT_CHAR
  // supplies its final cycle, so every character still lasts 10*DIV cycles.
  localparam logic [BW-1:0] DIV_M2   = (DIV >= 2) ? BW'(DIV - 2) : '0;
  localparam logic [3:0]    LAST_IDX = 4'(NCHAR - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    NEXT_CHAR = 3'd4
  } state_t;

  state_t         r_state;
  logic           r_txd;
  logic           r_busy;
  logic           r_done;
  logic [BW-1:0]  r_baud;
  logic [2:0]     r_bit;
  logic [3:0]     r_idx;
  logic [31:0]    r_word;

  logic [3:0]     w_nib;
  logic [7:0]     w_char;
  logic [2:0]     w_next_bit;

  // Character currently being sent: indices 0..7 are hex digits, 8 is CR
  // and 9 is LF.
  always_comb begin
    w_nib = 4'h0;
    case (r_idx)
      4'd0:    w_nib = r_word[31:28];
      4'd1:    w_nib = r_word[27:24];
      4'd2:    w_nib = r_word[23:20];
      4'd3:    w_nib = r_word[19:16];
      4'd4:    w_nib = r_word[15:12];
      4'd5:    w_nib = r_word[11:8];
      4'd6:    w_nib = r_word[7:4];
      4'd7:    w_nib = r_word[3:0];
      default: w_nib = 4'h0;
    endcase
    if (r_idx == 4'd8)       w_char = 8'h0D;
    else if (r_idx == 4'd9)  w_char = 8'h0A;
    else if (w_nib < 4'd10)  w_char = 8'h30 + {4'h0, w_nib};
    else                     w_char = 8'h37 + {4'h0, w_nib}; // 10 -> 'A' (0x41)
  end

  assign w_next_bit = r_bit + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_baud  <= '0;
      r_bit   <= '0;
      r_idx   <= '0;
      r_word  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_txd  <= 1'b1;
          r_busy <= 1'b0;
          r_baud <= '0;
          if (start) begin
            r_word  <= din;
            r_idx   <= '0;
            r_bit   <= '0;
            r_txd   <= 1'b0;   // start bit is on the line in the next cycle
            r_busy  <= 1'b1;
            r_state <= START_BIT;
          end
        end
        START_BIT: begin
          if (r_baud == DIV_M1) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_txd   <= w_char[0];
            r_state <= DATA_BITS;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        DATA_BITS: begin
          if (r_baud == DIV_M1) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= (DIV == 1) ? NEXT_CHAR : STOP_BIT;
            end else begin
              r_bit <= w_next_bit;
              r_txd <= w_char[w_next_bit];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        STOP_BIT: begin
          if (r_baud == DIV_M2) begin
            r_baud  <= '0;
            r_state <= NEXT_CHAR;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        NEXT_CHAR: begin
          // Last cycle of the stop bit. busy stays high through the done cycle.
          if (r_idx == LAST_IDX) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_idx   <= r_idx + 4'd1;
            r_txd   <= 1'b0;
            r_state <= START_BIT;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign txd         = r_txd;
  assign busy        = r_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_hex_uart_tx.sv
// Directed bench for hex_uart_tx. Three instances share one clock:
//   a: DIV=16, CR LF on   b: DIV=16, CR LF off   c: default parameters
module tb_hex_uart_tx;

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0;
  int   cyc = 0;
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_a, start_a, txd_a, busy_a, done_a;
  logic        rst_b, start_b, txd_b, busy_b, done_b;
  logic        rst_c, start_c, txd_c, busy_c, done_c;
  logic [31:0] din_a, din_b, din_c;
  logic [2:0]  st_a, st_b, st_c;

  hex_uart_tx #(.CLK_FREQ(16), .BAUD(1), .NEWLINE(1)) u_a (
    .clk(clk), .rst(rst_a), .din(din_a), .start(start_a),
    .txd(txd_a), .busy(busy_a), .done(done_a), .o_dbg_state(st_a));
  hex_uart_tx #(.CLK_FREQ(16), .BAUD(1), .NEWLINE(0)) u_b (
    .clk(clk), .rst(rst_b), .din(din_b), .start(start_b),
    .txd(txd_b), .busy(busy_b), .done(done_b), .o_dbg_state(st_b));
  hex_uart_tx u_c (
    .clk(clk), .rst(rst_c), .din(din_c), .start(start_c),
    .txd(txd_c), .busy(busy_c), .done(done_c), .o_dbg_state(st_c));

  // Select which instance the receive/wait tasks observe.
  int   sel = 0;
  logic mon_txd, mon_busy, mon_done;
  always_comb begin
    mon_txd = txd_a; mon_busy = busy_a; mon_done = done_a;
    case (sel)
      1: begin mon_txd = txd_b; mon_busy = busy_b; mon_done = done_b; end
      2: begin mon_txd = txd_c; mon_busy = busy_c; mon_done = done_c; end
      default: ;
    endcase
  end

  int dcnt_a = 0, dcnt_b = 0;
  always @(posedge clk) begin
    if (done_a === 1'b1) dcnt_a <= dcnt_a + 1;
    if (done_b === 1'b1) dcnt_b <= dcnt_b + 1;
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver / monitor tasks ----------------
  // Called at a negedge; waits for a start bit, samples mid-bit, and
  // returns at the middle of the stop bit.
  task automatic rx_byte(input int div, output logic [7:0] b, output int t_start, output bit ok);
    int guard = 0;
    ok = 1'b1; b = 8'h00; t_start = cyc;
    while (mon_txd !== 1'b0 && guard < 40 * div) begin
      @(negedge clk); guard++;
    end
    if (mon_txd !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    t_start = cyc;
    repeat (div / 2) @(negedge clk);
    if (mon_txd !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (div) @(negedge clk);
      b[i] = mon_txd;
    end
    repeat (div) @(negedge clk);
    if (mon_txd !== 1'b1) ok = 1'b0;
  endtask

  task automatic rx_expect(input string tag, input int n, input int div, output int t_first);
    logic [7:0] b, e;
    int ts;
    bit ok;
    t_first = 0;
    for (int k = 0; k < n; k++) begin
      rx_byte(div, b, ts, ok);
      if (k == 0) t_first = ts;
      e = exp_q.pop_front();
      chk({tag, "_frame"}, {31'd0, ok}, 32'd1);
      chk({tag, "_byte"}, {24'd0, b}, {24'd0, e});
    end
  endtask

  task automatic wait_done(input int budget, output int t, output bit ok);
    int guard = 0;
    while (mon_done !== 1'b1 && guard < budget) begin
      @(negedge clk); guard++;
    end
    ok = (mon_done === 1'b1);
    t  = cyc;
  endtask

  task automatic run_len(output int n);
    logic v;
    v = mon_txd; n = 0;
    while (mon_txd === v && n < 5000) begin
      @(negedge clk); n++;
    end
  endtask

  // ---------------- directed sequence ----------------
  int  t0, td, t0b, td2, d0, n, zeros;
  bit  ok;
  int  rl_exp[9] = '{868, 868, 868, 868, 868, 1736, 1736, 868, 868};

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    din_a = 32'h0; din_b = 32'h0; din_c = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_txd_a", {31'd0, txd_a}, 32'd1);
    chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
    chk("rst_done_a", {31'd0, done_a}, 32'd0);
    chk("rst_state_a", {29'd0, st_a}, 32'd0);
    chk("rst_txd_b", {31'd0, txd_b}, 32'd1);
    chk("rst_state_b", {29'd0, st_b}, 32'd0);
    chk("rst_txd_c", {31'd0, txd_c}, 32'd1);
    chk("rst_state_c", {29'd0, st_c}, 32'd0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    repeat (2) @(negedge clk);

    // Word 0x1234ABCD with CR LF
    sel = 0; d0 = dcnt_a;
    din_a = 32'h1234ABCD; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    chk("t1_start_bit", {31'd0, mon_txd}, 32'd0);
    chk("t1_busy", {31'd0, mon_busy}, 32'd1);
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
    rx_expect("t1", 10, 16, t0);
    wait_done(200, td, ok);
    chk("t1_done_seen", {31'd0, ok}, 32'd1);
    chk("t1_duration", td - t0, 32'd1600);
    chk("t1_busy_at_done", {31'd0, mon_busy}, 32'd1);
    @(negedge clk);
    chk("t1_done_width", {31'd0, mon_done}, 32'd0);
    chk("t1_busy_fall", {31'd0, mon_busy}, 32'd0);
    chk("t1_txd_idle", {31'd0, mon_txd}, 32'd1);
    repeat (4) @(negedge clk);
    chk("t1_done_count", dcnt_a - d0, 32'd1);

    // Word 0x00000000 without CR LF
    sel = 1; d0 = dcnt_b;
    din_b = 32'h0; start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    chk("t2_start_bit", {31'd0, mon_txd}, 32'd0);
    for (int k = 0; k < 8; k++) exp_q.push_back(8'h30);
    rx_expect("t2", 8, 16, t0);
    wait_done(200, td, ok);
    chk("t2_done_seen", {31'd0, ok}, 32'd1);
    chk("t2_duration", td - t0, 32'd1280);
    chk("t2_busy_at_done", {31'd0, mon_busy}, 32'd1);
    @(negedge clk);
    chk("t2_busy_fall", {31'd0, mon_busy}, 32'd0);
    zeros = 0;
    repeat (200) begin
      if (mon_txd !== 1'b1) zeros++;
      @(negedge clk);
    end
    chk("t2_no_crlf", zeros, 32'd0);
    chk("t2_done_count", dcnt_b - d0, 32'd1);

    // 0xFFFFFFFF, then start + din change during char 3 must be ignored
    sel = 0; d0 = dcnt_a;
    din_a = 32'hFFFFFFFF; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int k = 0; k < 8; k++) exp_q.push_back(8'h46);
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    rx_expect("t3a", 3, 16, t0);
    din_a = 32'h0; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    rx_expect("t3b", 7, 16, t0b);
    wait_done(200, td, ok);
    chk("t3_done_seen", {31'd0, ok}, 32'd1);
    chk("t3_duration", td - t0, 32'd1600);
    repeat (40) @(negedge clk);
    chk("t3_done_count", dcnt_a - d0, 32'd1);
    chk("t3_idle_after", {31'd0, mon_txd}, 32'd1);

    // Reset mid data bit of char 5, then restart in the first cycle
    d0 = dcnt_a;
    din_a = 32'h13579BDF; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    exp_q = '{8'h31, 8'h33, 8'h35, 8'h37, 8'h39};
    rx_expect("t4a", 5, 16, t0);
    repeat (64) @(negedge clk);
    chk("t4_in_data", {29'd0, st_a}, 32'd2);
    rst_a = 1'b1;
    @(negedge clk); rst_a = 1'b0;
    chk("t4_rst_txd", {31'd0, txd_a}, 32'd1);
    chk("t4_rst_busy", {31'd0, busy_a}, 32'd0);
    chk("t4_rst_done", {31'd0, done_a}, 32'd0);
    din_a = 32'h89ABCDEF; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    chk("t4_first_cycle_accept", {31'd0, txd_a}, 32'd0);
    exp_q = '{8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h0D, 8'h0A};
    rx_expect("t4b", 10, 16, t0);
    wait_done(200, td, ok);
    chk("t4_done_seen", {31'd0, ok}, 32'd1);
    chk("t4_duration", td - t0, 32'd1600);
    repeat (4) @(negedge clk);
    chk("t4_done_count", dcnt_a - d0, 32'd1);

    // start held high: two back-to-back words of 0x00000001
    d0 = dcnt_a;
    din_a = 32'h00000001; start_a = 1'b1;
    @(negedge clk);
    chk("t5_start_bit1", {31'd0, txd_a}, 32'd0);
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 7; k++) exp_q.push_back(8'h30);
      exp_q.push_back(8'h31); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    end
    rx_expect("t5a", 10, 16, t0);
    wait_done(200, td, ok);
    chk("t5_done1_seen", {31'd0, ok}, 32'd1);
    chk("t5_duration1", td - t0, 32'd1600);
    @(negedge clk);
    chk("t5_back_to_back", {31'd0, txd_a}, 32'd0);
    chk("t5_busy_held", {31'd0, busy_a}, 32'd1);
    start_a = 1'b0;
    rx_expect("t5b", 10, 16, t0b);
    chk("t5_gap", t0b - td, 32'd1);
    wait_done(200, td2, ok);
    chk("t5_done2_seen", {31'd0, ok}, 32'd1);
    chk("t5_duration2", td2 - t0b, 32'd1600);
    @(negedge clk);
    chk("t5_busy_fall", {31'd0, busy_a}, 32'd0);
    repeat (40) @(negedge clk);
    chk("t5_done_count", dcnt_a - d0, 32'd2);
    chk("t5_no_third_word", {31'd0, txd_a}, 32'd1);

    // Default parameters: bit periods of the first character frame
    sel = 2;
    chk("t6_idle_before", {31'd0, mon_txd}, 32'd1);
    din_c = 32'h55555555; start_c = 1'b1;
    @(negedge clk); start_c = 1'b0;
    chk("t6_start_bit", {31'd0, mon_txd}, 32'd0);
    for (int k = 0; k < 9; k++) begin
      run_len(n);
      chk("t6_run_len", n, rl_exp[k]);
    end
    rst_c = 1'b1;
    @(negedge clk); rst_c = 1'b0;
    chk("t6_idle_after", {31'd0, mon_txd}, 32'd1);
    chk("t6_busy_after", {31'd0, mon_busy}, 32'd0);
    repeat (20) @(negedge clk);
    chk("t6_idle_hold", {31'd0, mon_txd}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_uart_tx.md
HEX_UART_TX -- requirements
Module: hex_uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate in bit/s.
REQ-003 Parameter NEWLINE, default 1, nonzero appends CR (0x0D) LF (0x0A) after the hex digits.
REQ-004 clk  input  1  single system clock, all logic on posedge; 100 MHz in the PDU.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 din  input  32  word to print as hexadecimal.
REQ-007 start  input  1  request to transmit din; level-sampled each cycle.
REQ-008 txd  output  1  UART serial line, 8N1, idle high.
REQ-009 busy  output  1  high while a word is being transmitted.
REQ-010 done  output  1  one-cycle pulse when the last stop bit of a word completes.

Function
REQ-011 Bit period DIV = CLK_FREQ/BAUD, integer-truncated (868 at defaults); every serial bit shall last exactly DIV cycles.
REQ-012 FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT, NEXT_CHAR.
REQ-013 IDLE: txd=1, busy=0; start=1 at a clock edge latches din into an internal word register, clears the char index, and enters START_BIT at that edge.
REQ-014 busy shall be 1 from the cycle after start acceptance until done is asserted, inclusive of the done cycle.
REQ-015 txd shall be registered; the start bit (0) shall appear on txd in the cycle after start acceptance.
REQ-016 Character sequence: 8 ASCII hex digits, most-significant nibble (din[31:28]) first, then, if NEWLINE is nonzero, 0x0D then 0x0A.
REQ-017 Nibble mapping: 0-9 -> 0x30-0x39; A-F -> 0x41-0x46 (uppercase only).
REQ-018 Each character frame: one start bit 0, eight data bits LSB first, one stop bit 1; no idle gap between characters of one word.
REQ-019 NEXT_CHAR: if characters remain, increment the index and enter START_BIT; otherwise pulse done and return to IDLE.
REQ-020 Word duration: exactly 10*DIV*N cycles from the first start-bit cycle to the done cycle, N = 10 (NEWLINE nonzero) or 8.
REQ-021 start while busy=1 shall be ignored and not queued; din changes after acceptance shall not affect the output.
REQ-022 start held high continuously shall start a new word in the cycle following done (back-to-back), with txd held at 1 for no more than one cycle between words.
REQ-023 done shall never be asserted outside the single cycle ending a word.

Reset
REQ-024 With rst=1 at a clock edge: state=IDLE, txd=1, busy=0, done=0, baud counter, bit counter and char index = 0, word register = 0.
REQ-025 rst shall take priority over start and override any in-progress frame; the partial character is abandoned and no done pulse is produced.
REQ-026 After rst deasserts, the block shall accept start in the first cycle.

Verification
REQ-027 CLK_FREQ=16, BAUD=1 (DIV=16), NEWLINE=1; din=0x1234ABCD, start pulsed 1 cycle -> UART monitor decodes 0x31,0x32,0x33,0x34,0x41,0x42,0x43,0x44,0x0D,0x0A; done pulses exactly once, 1600 cycles after the first start bit.
REQ-028 din=0x00000000, NEWLINE=0 -> eight 0x30 bytes, no CR/LF, word duration 1280 cycles, busy falls after done.
REQ-029 din=0xFFFFFFFF accepted; start pulsed again and din changed to 0x0 at char 3 -> output remains eight 0x46 (+CR LF), single done pulse.
REQ-030 rst asserted for one cycle mid data bit of char 5 -> next cycle txd=1, busy=0, no done; a subsequent start with din=0x89ABCDEF transmits "89ABCDEF" correctly.
REQ-031 start held high for two words with din=0x00000001 -> two complete frames, second start bit no more than one cycle after the first done.
REQ-032 Defaults (DIV=868) single word -> each bit period measured at 868 cycles, txd idle 1 before and after.
